// File: rtl/conv_pkg.sv
// +----------------------------------------------------------------------+
// | conv_pkg : shared types and helpers for the conv weight scheduler    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package conv_pkg;

    localparam int IC2_LANES_DEF = 16;
    localparam int OC2_LANES_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG       = 3'd1,
        WAIT_LOAD = 3'd2,
        REQ       = 3'd3,
        WAIT_WGT  = 3'd4,
        DONE      = 3'd5
    } wsched_state_t;

    function automatic logic wgt_bits_legal(input logic [4:0] bits);
        return (bits == 5'd2) || (bits == 5'd4) || (bits == 5'd8) || (bits == 5'd16);
    endfunction

    // log2 of bits/2, i.e. the number of 2-bit slices per weight
    function automatic int slices_log2(input logic [4:0] bits);
        case (bits)
            5'd4:    return 1;
            5'd8:    return 2;
            5'd16:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int ocpc(input logic [4:0] bits, input int oc2_lanes);
        return oc2_lanes >> slices_log2(bits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wgt_grp_sched.sv
// +----------------------------------------------------------------------+
// | wgt_grp_sched : walks (oc_grp, ic_grp) weight blocks, forwards them  |
// | to the conv core. Optional perf counters: WGT_SCHED_PERF_EN.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module wgt_grp_sched
    import conv_pkg::*;
#(
    parameter int IC2_LANES = IC2_LANES_DEF,
    parameter int OC2_LANES = OC2_LANES_DEF,
    parameter int GRP_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_IC,
    input  logic [15:0]      cfg_OC,
    input  logic [4:0]       cfg_wgt_bits,
    input  logic             wgt_load_done,
    output logic [GRP_W-1:0] req_oc_grp,
    output logic [GRP_W-1:0] req_ic_grp,
    output logic             req_valid,
    input  logic             req_ready,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_first_ic,
    output logic             blk_last_ic,
    output logic             busy,
    output logic             done,
`ifdef WGT_SCHED_PERF_EN
    output logic [31:0]      perf_stall_cyc,
    output logic [15:0]      perf_blk_cnt,
`endif
    output logic             err
);

    localparam int IC_LOG2 = $clog2(IC2_LANES);
    localparam int OC_LOG2 = $clog2(OC2_LANES);

    wsched_state_t    state_q, state_d;
    logic [15:0]      cfg_ic_q, cfg_oc_q;
    logic [4:0]       cfg_bits_q;
    logic [GRP_W-1:0] n_oc_q, n_ic_q;
    logic [GRP_W-1:0] oc_cnt_q, oc_cnt_d, ic_cnt_q, ic_cnt_d;
    logic             loaded_q, err_q;

    logic             w_start_acc, w_blk_hs, w_last_ic, w_last_oc, w_cfg_legal;
    logic [16:0]      w_oc_sum, w_ic_sum;
    int               w_oc_shift;

    assign w_start_acc = (state_q == IDLE) && start && !abort;
    assign w_blk_hs    = (state_q == WAIT_WGT) && wgt_valid && blk_ready && !abort;
    assign w_last_ic   = (ic_cnt_q == n_ic_q - GRP_W'(1));
    assign w_last_oc   = (oc_cnt_q == n_oc_q - GRP_W'(1));
    assign w_cfg_legal = wgt_bits_legal(cfg_bits_q) && (|cfg_oc_q) && (|cfg_ic_q);

    // ceil(x/d) as (x+d-1)>>log2(d); the lane counts are powers of two
    assign w_oc_shift = OC_LOG2 - slices_log2(cfg_bits_q);
    assign w_oc_sum   = {1'b0, cfg_oc_q} + 17'(ocpc(cfg_bits_q, OC2_LANES)) - 17'd1;
    assign w_ic_sum   = {1'b0, cfg_ic_q} + 17'(IC2_LANES - 1);

    always_comb begin
        state_d   = state_q;
        oc_cnt_d  = oc_cnt_q;
        ic_cnt_d  = ic_cnt_q;
        req_valid = 1'b0;
        wgt_ready = 1'b0;
        blk_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:      if (start) state_d = CFG;
            CFG: begin
                oc_cnt_d = '0;
                ic_cnt_d = '0;
                state_d  = w_cfg_legal ? WAIT_LOAD : IDLE;
            end
            WAIT_LOAD: if (loaded_q || wgt_load_done) state_d = REQ;
            REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_d = WAIT_WGT;
            end
            WAIT_WGT: begin
                blk_valid = wgt_valid;
                wgt_ready = blk_ready;
                if (wgt_valid && blk_ready) begin
                    state_d = REQ;
                    if (w_last_ic) begin
                        ic_cnt_d = '0;
                        if (w_last_oc) begin
                            oc_cnt_d = '0;
                            state_d  = DONE;
                        end else begin
                            oc_cnt_d = oc_cnt_q + GRP_W'(1);
                        end
                    end else begin
                        ic_cnt_d = ic_cnt_q + GRP_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drains any block the buffer is already presenting
        if (abort) begin
            state_d   = IDLE;
            oc_cnt_d  = '0;
            ic_cnt_d  = '0;
            req_valid = 1'b0;
            blk_valid = 1'b0;
            wgt_ready = (state_q == WAIT_WGT) && wgt_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            oc_cnt_q   <= '0;
            ic_cnt_q   <= '0;
            n_oc_q     <= '0;
            n_ic_q     <= '0;
            cfg_ic_q   <= '0;
            cfg_oc_q   <= '0;
            cfg_bits_q <= '0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            oc_cnt_q <= oc_cnt_d;
            ic_cnt_q <= ic_cnt_d;
            if (w_start_acc) begin
                cfg_ic_q   <= cfg_IC;
                cfg_oc_q   <= cfg_OC;
                cfg_bits_q <= cfg_wgt_bits;
            end
            if (state_q == CFG) begin
                n_oc_q <= GRP_W'(w_oc_sum >> w_oc_shift);
                n_ic_q <= GRP_W'(w_ic_sum >> IC_LOG2);
            end
            if (abort || state_q == DONE) loaded_q <= 1'b0;
            else if (wgt_load_done)       loaded_q <= 1'b1;
            if (w_start_acc)                                        err_q <= 1'b0;
            else if (state_q == CFG && !w_cfg_legal && !abort)     err_q <= 1'b1;
        end
    end

    assign req_oc_grp   = oc_cnt_q;
    assign req_ic_grp   = ic_cnt_q;
    assign blk_first_ic = (ic_cnt_q == '0);
    assign blk_last_ic  = w_last_ic;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

`ifdef WGT_SCHED_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_blk_q;
    logic        w_stall;

    assign w_stall = ((state_q == WAIT_WGT) && wgt_valid && !blk_ready) ||
                     ((state_q == REQ) && !req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            perf_stall_q <= '0;
            perf_blk_q   <= '0;
        end else begin
            if (w_stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            if (w_blk_hs && perf_blk_q != '1)  perf_blk_q   <= perf_blk_q + 16'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_blk_cnt   = perf_blk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wgt_grp_sched.sv
// +----------------------------------------------------------------------+
// | tb_wgt_grp_sched : scoreboard bench for wgt_grp_sched                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wgt_grp_sched;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, wgt_load_done;
    logic [15:0] cfg_IC, cfg_OC;
    logic [4:0]  cfg_wgt_bits;
    logic [7:0]  req_oc_grp, req_ic_grp;
    logic        req_valid, req_ready, wgt_valid, wgt_ready;
    logic        blk_valid, blk_ready, blk_first_ic, blk_last_ic;
    logic        busy, done, err;
`ifdef WGT_SCHED_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_blk_cnt;
`endif

    wgt_grp_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_IC        (cfg_IC),
        .cfg_OC        (cfg_OC),
        .cfg_wgt_bits  (cfg_wgt_bits),
        .wgt_load_done (wgt_load_done),
        .req_oc_grp    (req_oc_grp),
        .req_ic_grp    (req_ic_grp),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .wgt_valid     (wgt_valid),
        .wgt_ready     (wgt_ready),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_first_ic  (blk_first_ic),
        .blk_last_ic   (blk_last_ic),
        .busy          (busy),
        .done          (done),
`ifdef WGT_SCHED_PERF_EN
        .perf_stall_cyc(perf_stall_cyc),
        .perf_blk_cnt  (perf_blk_cnt),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] oc;
        logic [7:0] ic;
        logic       first;
        logic       last;
    } blk_t;

    blk_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs = -10;
    int   done_cnt = 0;
    int   req_mode = 1;   // 0 random, 1 always high, 2 always low
    int   blk_mode = 1;
    int   max_lat = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Block order straight from the layer definition: oc outer, ic inner
    task automatic model_push(input int b, input int oc, input int ic);
        int ocpc_m, noc, nic;
        blk_t e;
        if (!(b == 2 || b == 4 || b == 8 || b == 16) || oc == 0 || ic == 0) return;
        ocpc_m = 16 / (b / 2);
        noc    = (oc + ocpc_m - 1) / ocpc_m;
        nic    = (ic + 15) / 16;
        for (int o = 0; o < noc; o++)
            for (int i = 0; i < nic; i++) begin
                e.oc    = 8'(o);
                e.ic    = 8'(i);
                e.first = (i == 0);
                e.last  = (i == nic - 1);
                exp_q.push_back(e);
            end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Weight buffer and conv-core ready model
    initial begin
        bit pend, rq_hs, wg_hs;
        int lat;
        pend = 0; rq_hs = 0; wg_hs = 0; lat = 0;
        wgt_valid = 1'b0; req_ready = 1'b0; blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; rq_hs = 0; wg_hs = 0; wgt_valid = 1'b0;
            end
            if (wg_hs) begin
                wgt_valid = 1'b0;
                pend      = 0;
            end
            if (rq_hs) begin
                pend = 1;
                lat  = $urandom_range(0, max_lat);
            end
            if (pend && !wgt_valid) begin
                if (lat == 0) wgt_valid = 1'b1;
                else          lat--;
            end
            req_ready = (req_mode == 0) ? 1'($urandom_range(0, 1)) : (req_mode == 1);
            blk_ready = (blk_mode == 0) ? 1'($urandom_range(0, 1)) : (blk_mode == 1);
            #1;
            rq_hs = req_valid && req_ready;
            wg_hs = wgt_valid && wgt_ready;
        end
    end

    // Monitor: checks every request, forwarded block and done pulse
    initial forever begin
        blk_t e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) chk("req_unexpected", 1, 0);
                else chk("req_grp", {req_oc_grp, req_ic_grp}, {exp_q[0].oc, exp_q[0].ic});
            end
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) chk("blk_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("blk_grp_flags", {req_oc_grp, req_ic_grp, blk_first_ic, blk_last_ic},
                        {e.oc, e.ic, e.first, e.last});
                end
                last_hs = cyc;
            end
            if (done) begin
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_latency", cyc - last_hs, 1);
                done_cnt++;
            end
        end
    end

    task automatic pulse_load();
        @(negedge clk);
        wgt_load_done = 1'b1;
        @(negedge clk);
        wgt_load_done = 1'b0;
    endtask

    task automatic do_start(input int b, input int oc, input int ic);
        @(negedge clk);
        cfg_wgt_bits = 5'(b);
        cfg_OC       = 16'(oc);
        cfg_IC       = 16'(ic);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input int d0, input string nm);
        bit got = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
        end
        chk(nm, got, 1);
    endtask

    task automatic run_cfg(input int b, input int oc, input int ic,
                           input bit preload, input bit chk_lat);
        int d0, k;
        model_push(b, oc, ic);
        if (preload) pulse_load();
        d0 = done_cnt;
        do_start(b, oc, ic);
        chk("err_clear_on_start", err, 0);
        if (chk_lat) begin
            k = 1;
            while (!req_valid && k < 20) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("start_to_req", k, 3);
        end
        if (!preload) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            pulse_load();
        end
        wait_done(d0, "done_seen");
        @(negedge clk);
        #1;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic err_case(input int b, input int oc, input int ic);
        int d0;
        bit seen = 0;
        d0 = done_cnt;
        do_start(b, oc, ic);
        repeat (6) begin
            @(negedge clk);
            #1;
            if (req_valid) seen = 1;
        end
        chk("err_flag", err, 1);
        chk("err_no_req", seen, 0);
        chk("err_idle", busy, 0);
        chk("err_no_done", done_cnt, d0);
    endtask

    initial begin
        int bt[4];
        int d0;
        bit got, seen;
        logic [15:0] g0;
        bt = '{2, 4, 8, 16};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wgt_load_done = 1'b0;
        cfg_IC = '0; cfg_OC = '0; cfg_wgt_bits = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {req_valid, wgt_ready, blk_valid, done, err}, 0);
        chk("rst_grp", {req_oc_grp, req_ic_grp}, 0);
        chk("rst_first_last", {blk_first_ic, blk_last_ic}, 2'b10);

        // Basic 2x2 walk with preloaded weights
        req_mode = 1; blk_mode = 1; max_lat = 0;
        run_cfg(2, 32, 32, 1, 1);

        // 16-bit weights, 10x2 blocks under random back-pressure
        req_mode = 0; blk_mode = 0; max_lat = 3;
        run_cfg(16, 20, 17, 1, 0);

        for (int n = 0; n < 6; n++)
            run_cfg(bt[$urandom_range(0, 3)], $urandom_range(1, 64), $urandom_range(1, 80),
                    1'($urandom_range(0, 1)), 0);

        // Illegal configurations, then a legal layer
        err_case(6, 16, 16);
        err_case(4, 0, 16);
        err_case(8, 16, 0);
        req_mode = 1; blk_mode = 1; max_lat = 1;
        run_cfg(4, 16, 16, 1, 1);

        // Stall the conv core for 5 cycles on the first block
        blk_mode = 2; req_mode = 1;
        model_push(4, 16, 32);
        pulse_load();
        d0 = done_cnt;
        do_start(4, 16, 32);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (blk_valid) begin
                got = 1;
                break;
            end
        end
        chk("stall_blk_present", got, 1);
        g0 = {req_oc_grp, req_ic_grp};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("stall_hold", {wgt_ready, req_oc_grp, req_ic_grp}, {1'b0, g0});
        end
        @(posedge clk);
        blk_mode = 1;
        wait_done(d0, "stall_done");
        @(negedge clk);
        #1;
`ifdef WGT_SCHED_PERF_EN
        chk("perf_stall", perf_stall_cyc, 5);
        chk("perf_blk", perf_blk_cnt, 4);
`endif

        // Abort while a block is waiting on the conv core
        blk_mode = 2; req_mode = 1; max_lat = 0;
        model_push(8, 16, 64);
        pulse_load();
        d0 = done_cnt;
        do_start(8, 16, 64);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (blk_valid) begin
                got = 1;
                break;
            end
        end
        chk("abort_blk_present", got, 1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_drain_ready", wgt_ready, 1);
        chk("abort_no_forward", blk_valid, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_grp_clear", {req_oc_grp, req_ic_grp}, 0);
        chk("abort_ready_low", wgt_ready, 0);
        exp_q.delete();
        chk("abort_no_done", done_cnt, d0);

        // Loaded flag was cleared by abort: requests wait for the load pulse
        blk_mode = 1;
        model_push(8, 8, 16);
        d0 = done_cnt;
        @(negedge clk);
        cfg_wgt_bits = 5'd8; cfg_OC = 16'd8; cfg_IC = 16'd16;
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (req_valid) seen = 1;
        end
        chk("load_wait_no_req", seen, 0);
        wgt_load_done = 1'b1;
        @(negedge clk);
        wgt_load_done = 1'b0;
        #1;
        chk("load_to_req", req_valid, 1);
        wait_done(d0, "load_wait_done");

        repeat (3) @(negedge clk);
        chk("end_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wgt_grp_sched.md
# wgt_grp_sched

Layer-level scheduler sitting between the conv control FSM and the weight buffer. Once the layer's weights are loaded, it walks every (oc_grp, ic_grp) weight block in a fixed order. For each block it issues one request to the buffer and forwards the returned block to the conv core under a valid/ready handshake, tagging it with first/last-IC flags for accumulator control. It raises `done` after the final block is consumed.

## Interface
- `IC2_LANES`, 16: input channels per block.
- `OC2_LANES`, 16: 2-bit output lanes per block.
- `GRP_W`, 8: width of the group index and counters.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle layer start; accepted only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `cfg_IC`, `cfg_OC`  in  16 each  layer channel counts, sampled on `start`.
- `cfg_wgt_bits`  in  5  2/4/8/16, sampled on `start`.
- `wgt_load_done`  in  1  pulse from the weight buffer.
- `req_oc_grp`, `req_ic_grp`  out  GRP_W each  block index to the buffer.
- `req_valid`  out  1; `req_ready`  in  1.
- `wgt_valid`  in  1; `wgt_ready`  out  1  buffer block handshake.
- `blk_valid`  out  1; `blk_ready`  in  1  handshake toward the conv core.
- `blk_first_ic`, `blk_last_ic`  out  1 each  the current block is ic_grp 0 / the last ic_grp.
- `busy`  out  1; `done`  out  1 (pulse); `err`  out  1 (sticky until the next accepted `start`).

## Operation
- Derived values at `start`:
  - slices = bits/2
  - ocpc = OC2_LANES/slices
  - n_oc = ceil(OC/ocpc)
  - n_ic = ceil(IC/IC2_LANES)
  - All are registered in the CFG state.
- Illegal configuration (bits ∉ {2,4,8,16}, OC=0, or IC=0):
  - `err` = 1; go to IDLE; no request is issued; no `done`.
- Loaded flag:
  - Set by `wgt_load_done` in any state, so a pulse before `start` still counts.
  - Cleared on DONE and on `abort`.
- Loop order: ic_grp is the inner loop, oc_grp the outer: (0,0), (0,1) … (0,n_ic-1), (1,0) …
- States:
  - IDLE → CFG on `start`.
  - CFG → err ? IDLE : WAIT_LOAD.
  - WAIT_LOAD → REQ when the loaded flag is set.
  - REQ drives `req_valid` = 1 → WAIT_WGT on `req_ready`.
  - WAIT_WGT → on `wgt_valid & blk_ready`: advance the counters; go to DONE if (oc,ic) = (n_oc-1, n_ic-1), else REQ.
  - DONE pulses `done` → IDLE.
- In WAIT_WGT the block passes through combinationally:
  - `blk_valid` = `wgt_valid`.
  - `wgt_ready` = `blk_ready`.
  - Both are 0 in every other state.
- `req_oc_grp`/`req_ic_grp` always show the current counters. They are held stable while `req_valid` is high.
- `blk_first_ic` = (ic_cnt = 0); `blk_last_ic` = (ic_cnt = n_ic-1). Both are valid while `blk_valid` is high.
- `abort` has priority over every transition:
  - Next state is IDLE; counters are cleared.
  - An in-flight buffer block is drained: `wgt_ready` = 1 for that cycle only if `wgt_valid`.
- `start` outside IDLE is ignored.
- `busy` = state ≠ IDLE.

## Timing
- Reset values:
  - state IDLE; counters 0; loaded flag 0.
  - `req_valid`, `wgt_ready`, `blk_valid`, `done`, `err`, `busy` = 0.
  - `req_*_grp` = 0; `blk_first_ic` = 1; `blk_last_ic` = 0.
- `start` to first `req_valid`, with the loaded flag already set: 3 cycles (CFG, WAIT_LOAD, REQ).
- Block accept to the next `req_valid`: 1 cycle.
- Minimum per-block overhead is 1 REQ cycle plus the buffer's read latency.
- `done` fires the cycle after the last block handshake.
- Counter arithmetic is GRP_W wide.
  - Worst case is n_oc = 128 (16-bit weights, OC = 256), so no overflow.
  - ceil is computed as (x + d − 1)/d, with d a power of two (shift).

## Configuration
- `WGT_SCHED_PERF_EN`, when defined:
  - Adds outputs `perf_stall_cyc` (32 bits) and `perf_blk_cnt` (16 bits).
  - `perf_stall_cyc` counts cycles in WAIT_WGT with `wgt_valid & !blk_ready`, plus REQ cycles with `!req_ready`.
  - `perf_blk_cnt` counts forwarded blocks.
  - Both clear on an accepted `start`; both saturate.
- When undefined, these ports and counters are absent and the rest of the behaviour is identical.

## Structure
- Shared package `conv_pkg` holds:
  - The `wsched_state_t` enum (IDLE, CFG, WAIT_LOAD, REQ, WAIT_WGT, DONE).
  - The legal-bits check function and the `ocpc` function (OC2_LANES/slices).
  - The IC2_LANES/OC2_LANES default constants.
- No sub-module; the nested group counter is small enough to stay inline.

## Test plan
- bits=2, OC=32, IC=32, load done before `start`, `blk_ready` = 1 → 4 blocks in order (0,0), (0,1), (1,0), (1,1); first/last flags alternate; `done` 1 cycle after the 4th handshake.
- bits=16, OC=20, IC=17 → ocpc = 2, n_oc = 10, n_ic = 2, 20 blocks; `blk_last_ic` on every odd block.
- `start` with no load yet; `wgt_load_done` 10 cycles later → `req_valid` is held low until the pulse, then rises 1 cycle after it.
- `blk_ready` low for 5 cycles while `wgt_valid` = 1 → `wgt_ready` = 0 and counters frozen; with `WGT_SCHED_PERF_EN`, `perf_stall_cyc` = 5.
- bits=6, or OC=0 → `err` = 1, no `req_valid`, no `done`; a following legal `start` clears `err`.
- `abort` during WAIT_WGT with `wgt_valid` = 1 → a single drain cycle, then IDLE with counters 0 and `busy` = 0.
